// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache storage with true-LRU replacement, byte-merge
// write hits, refill, and a self-sequenced flush/write-back engine.
module dcache_sram_nway #(
    parameter int unsigned WAYS      = 4,
    parameter int unsigned SET_BITS  = 4,
    parameter int unsigned TAG_BITS  = 23,
    parameter int unsigned LINE_BITS = 256,
    localparam int unsigned AW       = $clog2(WAYS),
    localparam int unsigned SETS     = 2 ** SET_BITS,
    localparam int unsigned BE       = LINE_BITS / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic                  fill_i,
    input  logic [SET_BITS-1:0]   addr_i,
    input  logic [TAG_BITS-1:0]   tag_i,
    input  logic [LINE_BITS-1:0]  data_i,
    input  logic [BE-1:0]         be_i,
    output logic                  hit_o,
    output logic [AW-1:0]         way_o,
    output logic [TAG_BITS+1:0]   tag_o,
    output logic [LINE_BITS-1:0]  data_o,
    input  logic                  flush_i,
    input  logic                  flush_inv_i,
    output logic                  busy_o,
    output logic                  flush_done_o,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [SET_BITS-1:0]   wb_set_o,
    output logic [TAG_BITS-1:0]   wb_tag_o,
    output logic [LINE_BITS-1:0]  wb_data_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WB,
        ST_DONE
    } state_e;

    state_e state_q, state_d;

    logic                 valid_q [SETS][WAYS];
    logic                 valid_d [SETS][WAYS];
    logic                 dirty_q [SETS][WAYS];
    logic                 dirty_d [SETS][WAYS];
    logic [TAG_BITS-1:0]  tag_q   [SETS][WAYS];
    logic [TAG_BITS-1:0]  tag_d   [SETS][WAYS];
    logic [LINE_BITS-1:0] data_q  [SETS][WAYS];
    logic [LINE_BITS-1:0] data_d  [SETS][WAYS];
    logic [AW-1:0]        age_q   [SETS][WAYS];
    logic [AW-1:0]        age_d   [SETS][WAYS];

    logic [SET_BITS-1:0]  cur_set_q, cur_set_d;
    logic [AW-1:0]        cur_way_q, cur_way_d;
    logic                 inv_q, inv_d;

    logic                 hit;
    logic [AW-1:0]        hit_way;
    logic                 inv_found;
    logic [AW-1:0]        inv_way;
    logic [AW-1:0]        lru_way;
    logic [AW-1:0]        sel_way;
    logic                 busy;
    logic                 touch;
    logic                 clr_valid;
    logic                 clr_dirty;
    logic                 advance;
    logic                 last_line;

    // Lookup: hit way, else lowest invalid way, else the oldest way.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i)) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
            if (!valid_q[addr_i][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = AW'(w);
            end
            if (age_q[addr_i][w] == AW'(WAYS - 1)) begin
                lru_way = AW'(w);
            end
        end
        sel_way = hit ? hit_way : (inv_found ? inv_way : lru_way);
    end

    assign busy   = (state_q != ST_IDLE);
    assign busy_o = busy;

    always_comb begin
        hit_o  = 1'b0;
        way_o  = '0;
        tag_o  = '0;
        data_o = '0;
        if (!busy) begin
            hit_o  = hit;
            way_o  = sel_way;
            tag_o  = {valid_q[addr_i][sel_way], dirty_q[addr_i][sel_way], tag_q[addr_i][sel_way]};
            data_o = data_q[addr_i][sel_way];
        end
    end

    assign last_line = (cur_set_q == SET_BITS'(SETS - 1)) && (cur_way_q == AW'(WAYS - 1));

    // Flush engine: next state, cursor, and per-line clear requests.
    always_comb begin
        state_d      = state_q;
        cur_set_d    = cur_set_q;
        cur_way_d    = cur_way_q;
        inv_d        = inv_q;
        clr_valid    = 1'b0;
        clr_dirty    = 1'b0;
        advance      = 1'b0;
        flush_done_o = 1'b0;
        wb_valid_o   = 1'b0;
        wb_set_o     = '0;
        wb_tag_o     = '0;
        wb_data_o    = '0;
        case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    state_d   = ST_SCAN;
                    inv_d     = flush_inv_i;
                    cur_set_d = '0;
                    cur_way_d = '0;
                end
            end
            ST_SCAN: begin
                if (valid_q[cur_set_q][cur_way_q] && dirty_q[cur_set_q][cur_way_q]) begin
                    state_d = ST_WB;
                end else begin
                    clr_valid = inv_q;
                    advance   = 1'b1;
                end
            end
            ST_WB: begin
                wb_valid_o = 1'b1;
                wb_set_o   = cur_set_q;
                wb_tag_o   = tag_q[cur_set_q][cur_way_q];
                wb_data_o  = data_q[cur_set_q][cur_way_q];
                if (wb_ready_i) begin
                    clr_dirty = 1'b1;
                    clr_valid = inv_q;
                    advance   = 1'b1;
                end
            end
            ST_DONE: begin
                flush_done_o = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (advance) begin
            if (last_line) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_SCAN;
                if (cur_way_q == AW'(WAYS - 1)) begin
                    cur_way_d = '0;
                    cur_set_d = cur_set_q + SET_BITS'(1);
                end else begin
                    cur_way_d = cur_way_q + AW'(1);
                end
            end
        end
    end

    // Storage update: host accesses only run in IDLE, flush clears only outside it.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        age_d   = age_q;
        touch   = 1'b0;
        if (req_i && !busy) begin
            if (!we_i) begin
                touch = hit;
            end else if (fill_i) begin
                valid_d[addr_i][sel_way] = 1'b1;
                dirty_d[addr_i][sel_way] = 1'b0;
                tag_d[addr_i][sel_way]   = tag_i;
                data_d[addr_i][sel_way]  = data_i;
                touch                    = 1'b1;
            end else if (hit) begin
                for (int unsigned b = 0; b < BE; b++) begin
                    if (be_i[b]) begin
                        data_d[addr_i][sel_way][b*8 +: 8] = data_i[b*8 +: 8];
                    end
                end
                dirty_d[addr_i][sel_way] = 1'b1;
                touch                    = 1'b1;
            end
        end
        if (touch) begin
            for (int unsigned v = 0; v < WAYS; v++) begin
                if (AW'(v) == sel_way) begin
                    age_d[addr_i][v] = '0;
                end else if (age_q[addr_i][v] < age_q[addr_i][sel_way]) begin
                    age_d[addr_i][v] = age_q[addr_i][v] + AW'(1);
                end
            end
        end
        if (clr_valid) begin
            valid_d[cur_set_q][cur_way_q] = 1'b0;
        end
        if (clr_dirty) begin
            dirty_d[cur_set_q][cur_way_q] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cur_set_q <= '0;
            cur_way_q <= '0;
            inv_q     <= 1'b0;
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    data_q[s][w]  <= '0;
                    age_q[s][w]   <= AW'(w);
                end
            end
        end else begin
            state_q   <= state_d;
            cur_set_q <= cur_set_d;
            cur_way_q <= cur_way_d;
            inv_q     <= inv_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            age_q     <= age_d;
        end
    end

endmodule
